// File: rtl/i2s_ser_pkg.sv
// Shared constants, word-width enum and masking helper for the I2S serializer.
package i2s_ser_pkg;

   localparam int FRAME_BITS = 64;
   localparam int SLOT_BITS  = 32;

   typedef enum logic [1:0] {
      B16 = 2'd0,
      B24 = 2'd1,
      B32 = 2'd2
   } bitnum_e;

   // Clears the bits below the selected word width in both channels.
   function automatic logic [FRAME_BITS-1:0] mask_frame(input logic [FRAME_BITS-1:0] f,
                                                        input bitnum_e bn);
      logic [SLOT_BITS-1:0] m;
      case (bn)
         B16:     m = 32'hFFFF_0000;
         B24:     m = 32'hFFFF_FF00;
         default: m = 32'hFFFF_FFFF;
      endcase
      return f & {m, m};
   endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S timing grid: half-period counter, bck, 64-slot counter, lrck and
// the slot-boundary / frame-load strobes used by the datapath.
module i2s_clkgen #(
   parameter int BCK_HALF = 2
) (
   input  logic       clk,
   input  logic       reset,
   output logic       bck,
   output logic       lrck,
   output logic [5:0] slot,
   output logic       bnd,
   output logic       load,
   output logic       load_nxt
);

   localparam int HW = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
   localparam logic [HW-1:0] HMAX = HW'(BCK_HALF - 1);

   logic [HW-1:0] hcnt_q, hcnt_d;
   logic          bck_q, bck_d;
   logic          lrck_q, lrck_d;
   logic [5:0]    slot_q, slot_d;
   logic          wrap;

   always_comb begin
      wrap     = (hcnt_q == HMAX);
      hcnt_d   = wrap ? '0 : hcnt_q + 1'b1;
      bck_d    = wrap ? ~bck_q : bck_q;
      bnd      = wrap && bck_q;
      slot_d   = bnd ? slot_q + 6'd1 : slot_q;
      lrck_d   = slot_d[5];
      load     = bnd && (slot_q == 6'd0);
      // Predicts next clk's load so ready/underrun can be registered.
      load_nxt = (slot_d == 6'd0) && bck_d && (hcnt_d == HMAX);
      if (reset) begin
         hcnt_d   = '0;
         bck_d    = 1'b0;
         slot_d   = 6'd0;
         lrck_d   = 1'b0;
         load_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      hcnt_q <= hcnt_d;
      bck_q  <= bck_d;
      slot_q <= slot_d;
      lrck_q <= lrck_d;
   end

   assign bck  = bck_q;
   assign lrck = lrck_q;
   assign slot = slot_q;

endmodule

// File: rtl/i2s_ser.sv
// Parallel-to-I2S serializer: one-deep holding buffer, frame shifter with
// the I2S one-bck delay, and a registered underrun pulse on empty loads.
module i2s_ser
   import i2s_ser_pkg::*;
#(
   parameter int BCK_HALF = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [FRAME_BITS-1:0] data,
   input  logic                  valid,
   output logic                  ready,
   input  bitnum_e               bitnum,
   output logic                  bck,
   output logic                  lrck,
   output logic                  sdata,
   output logic                  underrun
);

   logic [5:0] slot;
   logic       bnd, load, load_nxt;

   i2s_clkgen #(.BCK_HALF(BCK_HALF)) u_clkgen (
      .clk      (clk),
      .reset    (reset),
      .bck      (bck),
      .lrck     (lrck),
      .slot     (slot),
      .bnd      (bnd),
      .load     (load),
      .load_nxt (load_nxt)
   );

   logic                  full_q, full_d;
   logic [FRAME_BITS-1:0] buf_q, buf_d;
   logic [FRAME_BITS-1:0] sh_q, sh_d;
   logic                  lsb_q, lsb_d;
   logic                  sdata_q, sdata_d;
   logic                  ready_q, ready_d;
   logic                  underrun_q, underrun_d;
   logic                  wr;
   logic [FRAME_BITS-1:0] ld_word;

   always_comb begin
      wr         = valid && ready_q;
      ld_word    = full_q ? mask_frame(buf_q, bitnum) : '0;
      full_d     = full_q;
      buf_d      = buf_q;
      sh_d       = sh_q;
      lsb_d      = lsb_q;
      sdata_d    = sdata_q;
      if (load) begin
         // Load coincides with the boundary into slot 1 (left MSB).
         full_d  = wr;
         sh_d    = ld_word;
         lsb_d   = ld_word[0];
         sdata_d = ld_word[FRAME_BITS-1];
      end else begin
         if (wr) full_d = 1'b1;
         if (bnd) begin
            if (slot == 6'd63) begin
               sdata_d = lsb_q;
            end else begin
               sh_d    = {sh_q[FRAME_BITS-2:0], sh_q[FRAME_BITS-1]};
               sdata_d = sh_q[FRAME_BITS-2];
            end
         end
      end
      if (wr) buf_d = data;
      ready_d    = !full_d || load_nxt;
      underrun_d = load_nxt && !full_d;
      if (reset) begin
         full_d     = 1'b0;
         buf_d      = '0;
         sh_d       = '0;
         lsb_d      = 1'b0;
         sdata_d    = 1'b0;
         ready_d    = 1'b1;
         underrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      full_q     <= full_d;
      buf_q      <= buf_d;
      sh_q       <= sh_d;
      lsb_q      <= lsb_d;
      sdata_q    <= sdata_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
   end

   assign sdata    = sdata_q;
   assign ready    = ready_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_ser.sv
// Self-checking bench for i2s_ser: time-based reference model checked every
// cycle, plus literal per-slot expectations for directed frames.
module tb_i2s_ser;
   import i2s_ser_pkg::*;

   localparam int BH  = 2;
   localparam int PER = 128 * BH;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        valid = 1'b0;
   logic [63:0] data = '0;
   bitnum_e     bitnum = B32;
   logic        ready, bck, lrck, sdata, underrun;

   i2s_ser #(.BCK_HALF(BH)) dut (
      .clk      (clk),
      .reset    (reset),
      .data     (data),
      .valid    (valid),
      .ready    (ready),
      .bitnum   (bitnum),
      .bck      (bck),
      .lrck     (lrck),
      .sdata    (sdata),
      .underrun (underrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state, valid for the current clk cycle t since reset release.
   int          t;
   logic        m_full;
   logic [63:0] m_buf;
   logic [63:0] m_cur;
   bit          started = 0;
   bit          cap [0:3][0:63];
   int          d_und, d_acc;

   function automatic logic [63:0] model_mask(input logic [63:0] f, input bitnum_e bn);
      int z;
      logic [31:0] hi, lo;
      z  = (bn == B16) ? 16 : (bn == B24) ? 8 : 0;
      hi = (f[63:32] >> z) << z;
      lo = (f[31:0] >> z) << z;
      return {hi, lo};
   endfunction

   function automatic bit m_load(input int tt);
      return (tt % PER) == (2 * BH - 1);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0d got %h want %h", name, t, act, exp);
      end
   endtask

   always @(posedge clk) begin
      bit ld, wr;
      started <= 1;
      if (reset) begin
         t      <= 0;
         m_full <= 1'b0;
         m_buf  <= '0;
         m_cur  <= '0;
      end else begin
         ld = m_load(t);
         wr = valid && (!m_full || ld);
         if (ld) begin
            m_cur  <= m_full ? model_mask(m_buf, bitnum) : 64'd0;
            m_full <= wr;
         end else if (wr) begin
            m_full <= 1'b1;
         end
         if (wr) m_buf <= data;
         t <= t + 1;
      end
   end

   always @(negedge clk) begin
      int  s, f;
      bit  ld;
      if (started) begin
         s  = (t / (2 * BH)) % 64;
         f  = t / PER;
         ld = m_load(t);
         chk("bck", 64'(bck), 64'((t / BH) % 2));
         chk("lrck", 64'(lrck), 64'(s >= 32));
         chk("ready", 64'(ready), 64'(!m_full || ld));
         chk("underrun", 64'(underrun), 64'(ld && !m_full));
         chk("sdata", 64'(sdata), 64'((s == 0) ? m_cur[0] : m_cur[64 - s]));
         if ((t % (2 * BH)) == BH && f < 4) cap[f][s] = sdata;
         if (reset) begin
            d_und = 0;
            d_acc = 0;
         end else begin
            if (underrun) d_und++;
            if (valid && ready) d_acc++;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      valid = 1'b0;
      cyc(2);
      reset = 1'b0;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_bck"}, 64'(bck), 64'd0);
      chk({tag, "_lrck"}, 64'(lrck), 64'd0);
      chk({tag, "_sdata"}, 64'(sdata), 64'd0);
      chk({tag, "_ready"}, 64'(ready), 64'd1);
      chk({tag, "_underrun"}, 64'(underrun), 64'd0);
   endtask

   initial begin
      // Idle: underrun once per frame, silent output.
      do_reset();
      chk_reset_outs("rst");
      cyc(2 * PER);
      chk("idle_und", 64'(d_und), 64'd2);
      chk("idle_s32", 64'(cap[1][32]), 64'd0);

      // Directed b32 frame written before the first load.
      do_reset();
      data   = {32'h8000_0001, 32'hC000_0003};
      bitnum = B32;
      valid  = 1'b1;
      cyc(1);
      valid  = 1'b0;
      cyc(2 * PER - 1);
      chk("b32_s1", 64'(cap[0][1]), 64'd1);
      chk("b32_s2", 64'(cap[0][2]), 64'd0);
      chk("b32_s31", 64'(cap[0][31]), 64'd0);
      chk("b32_s32", 64'(cap[0][32]), 64'd1);
      chk("b32_s33", 64'(cap[0][33]), 64'd1);
      chk("b32_s34", 64'(cap[0][34]), 64'd1);
      chk("b32_s35", 64'(cap[0][35]), 64'd0);
      chk("b32_s63", 64'(cap[0][63]), 64'd1);
      chk("b32_next_s0", 64'(cap[1][0]), 64'd1);
      chk("b32_und", 64'(d_und), 64'd1);

      // Same frame with 16-bit masking.
      do_reset();
      bitnum = B16;
      valid  = 1'b1;
      cyc(1);
      valid  = 1'b0;
      cyc(2 * PER - 1);
      chk("b16_s1", 64'(cap[0][1]), 64'd1);
      chk("b16_s32", 64'(cap[0][32]), 64'd0);
      chk("b16_s33", 64'(cap[0][33]), 64'd1);
      chk("b16_s34", 64'(cap[0][34]), 64'd1);
      chk("b16_s63", 64'(cap[0][63]), 64'd0);
      chk("b16_next_s0", 64'(cap[1][0]), 64'd0);

      // Continuous valid with data changing every clk.
      do_reset();
      bitnum = B32;
      valid  = 1'b1;
      for (int i = 0; i < 4 * PER; i++) begin
         data = {32'(i), ~32'(i)};
         cyc(1);
      end
      valid = 1'b0;
      chk("cont_acc", 64'(d_acc), 64'd5);
      chk("cont_und", 64'(d_und), 64'd0);
      chk("cont_f0_s1", 64'(cap[0][1]), 64'd0);
      chk("cont_f0_s33", 64'(cap[0][33]), 64'd1);
      chk("cont_f1_s32", 64'(cap[1][32]), 64'd1);
      chk("cont_f1_s31", 64'(cap[1][31]), 64'd1);
      chk("cont_f1_s30", 64'(cap[1][30]), 64'd0);

      // Reset in the middle of the right channel.
      do_reset();
      data  = '1;
      valid = 1'b1;
      cyc(1);
      valid = 1'b0;
      cyc(40 * 2 * BH);
      chk("mid_lrck", 64'(lrck), 64'd1);
      chk("mid_sdata", 64'(sdata), 64'd1);
      reset = 1'b1;
      cyc(1);
      chk_reset_outs("mid_rst");
      reset = 1'b0;
      cyc(PER);
      chk("mid_s0", 64'(cap[0][0]), 64'd0);
      chk("mid_s1", 64'(cap[0][1]), 64'd0);
      chk("mid_und", 64'(d_und), 64'd1);

      // Random traffic with random widths.
      do_reset();
      for (int i = 0; i < 3 * PER; i++) begin
         valid  = ($urandom_range(0, 3) != 0);
         data   = {$urandom, $urandom};
         bitnum = bitnum_e'($urandom_range(0, 2));
         cyc(1);
      end
      valid = 1'b0;
      cyc(8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
